mux4_rr_arbiter: RTL

- Shares the 4-input, 16-bit word mux datapath between four requesters using round-robin arbitration.
- Each requester presents a word on its own input port and raises its request line.
- The block picks one requester, drives the mux select, and captures the selected word into a one-entry output register.
- The output register presents the word downstream with a valid/ready handshake.

---
 rtl/mux4_rr_arbiter_pkg.sv | 20 ++
 rtl/mux4_rr_arbiter_mux4.sv | 30 +++
 rtl/mux4_rr_arbiter.sv | 79 +++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and the round-robin pick used by the 4-way word arbiter.
// The pick is a pure function so the winner logic stays a single expression in the top.
package mux4_rr_arbiter_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // First requester after 'last' in circular order; 'last' itself is searched last.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] cand;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (req[cand]) rr_pick = cand;
    end
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4.sv
// Word-wide 4:1 mux built as a tree of 2:1 muxes.
// sel[0] picks within each pair and sel[1] picks between the pairs.
module mux2 #(
  parameter int width = 16
) (
  input  logic             sel,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] y
);
  assign y = sel ? b : a;
endmodule

module mux4 #(
  parameter int width = 16
) (
  input  logic [1:0]       sel,
  input  logic [width-1:0] d0,
  input  logic [width-1:0] d1,
  input  logic [width-1:0] d2,
  input  logic [width-1:0] d3,
  output logic [width-1:0] y
);
  logic [width-1:0] lo;
  logic [width-1:0] hi;

  mux2 #(.width(width)) u_lo  (.sel(sel[0]), .a(d0), .b(d1), .y(lo));
  mux2 #(.width(width)) u_hi  (.sel(sel[0]), .a(d2), .b(d3), .y(hi));
  mux2 #(.width(width)) u_top (.sel(sel[1]), .a(lo), .b(hi), .y(y));
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 word mux between four requesters.
// The winner's word goes into a one-entry output register with a valid/ready handshake.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int word_size = 16,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           req,
  input  logic [word_size-1:0] d0,
  input  logic [word_size-1:0] d1,
  input  logic [word_size-1:0] d2,
  input  logic [word_size-1:0] d3,
  output logic [3:0]           gnt,
  output logic [1:0]           sel,
  output logic                 out_valid,
  output logic [word_size-1:0] out_data,
  input  logic                 out_ready,
  output logic [1:0]           out_src,
  output logic [cnt_width-1:0] grant_cnt
);

  state_t               state;
  logic [1:0]           last;
  logic [1:0]           idx;
  logic                 can_load;
  logic                 cap;
  logic [word_size-1:0] mux_out;

  // A full register may be refilled in the same cycle it drains, so there is no bubble.
  assign can_load = (state == EMPTY) || out_ready;
  assign cap      = !reset && can_load && (req != 4'b0000);
  assign idx      = rr_pick(req, last);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    gnt = 4'b0000;
    sel = last;
    if (reset) begin
      sel = 2'd0;
    end else if (cap) begin
      gnt = 4'b0001 << idx;
      sel = idx;
    end
  end

  mux4 #(.width(word_size)) u_mux (
    .sel(sel),
    .d0 (d0),
    .d1 (d1),
    .d2 (d2),
    .d3 (d3),
    .y  (mux_out)
  );

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      last      <= 2'd3;
      out_data  <= '0;
      out_src   <= 2'd0;
      grant_cnt <= '0;
    end else if (cap) begin
      state     <= FULL;
      last      <= idx;
      out_data  <= mux_out;
      out_src   <= idx;
      grant_cnt <= grant_cnt + 1'b1;
    end else if (state == FULL && out_ready) begin
      state <= EMPTY;
    end
  end

  assign out_valid = (state == FULL);

endmodule
